// File: rtl/halflife_decay_timer.sv
// Half-life decay timer: a WIDTH-bit value that halves every period_q
// decay-eligible cycles until it reaches zero, then reports expiry.
// Also supports saturating up/down nudges and a hold input.
module halflife_decay_timer #(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 16,
  parameter int ROUND    = 0,
  parameter int HCNT_W   = $clog2(WIDTH + 2)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                up_i,
  input  logic                down_i,
  input  logic                hold_i,
  input  logic [WIDTH-1:0]    in_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [WIDTH-1:0]    out_o,
  output logic                half_tick_o,
  output logic [HCNT_W-1:0]   halvings_o,
  output logic                busy_o,
  output logic                expired_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECAY   = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]    OUT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]    OUT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);
  localparam logic [HCNT_W-1:0]   HCNT_ONE = HCNT_W'(1);
  localparam logic [HCNT_W-1:0]   HCNT_MAX = '1;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [HCNT_W-1:0]   halvings_q, halvings_d;
  logic                half_tick_q, half_tick_d;
  logic [WIDTH-1:0]    half_val;

  // Halved value of the current output; rounding mode fixed at elaboration.
  generate
    if (ROUND == 0) begin : g_floor
      assign half_val = out_q >> 1;
    end else begin : g_round
      // out==1 must still reach 0, otherwise round-half-up would stall at 1.
      assign half_val = (out_q == OUT_ONE) ? '0
                      : (out_q >> 1) + {{(WIDTH-1){1'b0}}, out_q[0]};
    end
  endgenerate

  // Next-state logic: load > up > down > decay step (reset handled in the register).
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    period_d    = period_q;
    presc_d     = presc_q;
    halvings_d  = halvings_q;
    half_tick_d = 1'b0;

    if (load_i) begin
      out_d      = in_i;
      period_d   = (period_i == '0) ? PER_ONE : period_i;
      presc_d    = '0;
      halvings_d = '0;
      state_d    = (in_i != '0) ? S_DECAY : S_IDLE;
    end else if (up_i) begin
      out_d = (out_q == OUT_MAX) ? out_q : out_q + OUT_ONE;
      if (state_q == S_EXPIRED) begin
        state_d = S_IDLE;
      end
    end else if (down_i) begin
      out_d = (out_q == '0) ? out_q : out_q - OUT_ONE;
      // Draining to zero by hand is not an expiry, just a return to idle.
      if ((state_q == S_DECAY) && (out_d == '0)) begin
        state_d = S_IDLE;
      end
    end else if ((state_q == S_DECAY) && !hold_i) begin
      if (presc_q != (period_q - PER_ONE)) begin
        presc_d = presc_q + PER_ONE;
      end else begin
        presc_d     = '0;
        out_d       = half_val;
        half_tick_d = 1'b1;
        halvings_d  = (halvings_q == HCNT_MAX) ? halvings_q : halvings_q + HCNT_ONE;
        if (half_val == '0) begin
          state_d = S_EXPIRED;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      period_q    <= PER_ONE;
      presc_q     <= '0;
      halvings_q  <= '0;
      half_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      halvings_q  <= halvings_d;
      half_tick_q <= half_tick_d;
    end
  end

  assign out_o       = out_q;
  assign half_tick_o = half_tick_q;
  assign halvings_o  = halvings_q;
  assign busy_o      = (state_q == S_DECAY);
  assign expired_o   = (state_q == S_EXPIRED);

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Directed bench for halflife_decay_timer: a floor-rounding instance driven
// from a vector table, plus a round-half-up instance checked by hand sequence.
module tb_halflife_decay_timer;

  logic        clk = 1'b0;
  logic        rst, load, up, down, hold;
  logic [7:0]  din;
  logic [15:0] per;

  logic [7:0] out0, out1;
  logic       tick0, tick1;
  logic [3:0] halv0, halv1;
  logic       busy0, busy1, exp0, exp1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  halflife_decay_timer #(.WIDTH(8), .PERIOD_W(16), .ROUND(0)) u_r0 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .up_i(up), .down_i(down),
    .hold_i(hold), .in_i(din), .period_i(per), .out_o(out0),
    .half_tick_o(tick0), .halvings_o(halv0), .busy_o(busy0), .expired_o(exp0)
  );

  halflife_decay_timer #(.WIDTH(8), .PERIOD_W(16), .ROUND(1)) u_r1 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .up_i(up), .down_i(down),
    .hold_i(hold), .in_i(din), .period_i(per), .out_o(out1),
    .half_tick_o(tick1), .halvings_o(halv1), .busy_o(busy1), .expired_o(exp1)
  );

  typedef struct {
    logic        rst, ld, up, dn, hold;
    logic [7:0]  din;
    logic [15:0] per;
    int          reps;
    logic [7:0]  e_out;
    logic        e_tick;
    logic [3:0]  e_halv;
    logic        e_busy, e_exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic l, logic u, logic d, logic h,
                              logic [7:0] di, logic [15:0] p, int n,
                              logic [7:0] eo, logic et, logic [3:0] eh,
                              logic eb, logic ee);
    vec_t v;
    v.rst = r; v.ld = l; v.up = u; v.dn = d; v.hold = h;
    v.din = di; v.per = p; v.reps = n;
    v.e_out = eo; v.e_tick = et; v.e_halv = eh; v.e_busy = eb; v.e_exp = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, required %0d", nm, idx, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic u, input logic d,
                       input logic h, input logic [7:0] di, input logic [15:0] p);
    rst = r; load = l; up = u; down = d; hold = h; din = di; per = p;
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0, 8'd0, 16'd0);

    //        rst ld up dn ho  din   per  reps  out tick halv busy exp
    // reset state
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'd0,   16'd0, 2, 8'd0,   0, 4'd0, 0, 0));
    // floor decay 200, period 4
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd200, 16'd4, 1, 8'd200, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd100, 1, 4'd1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd50,  1, 4'd2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd25,  1, 4'd3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd12,  1, 4'd4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd6,   1, 4'd5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd3,   1, 4'd6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd1,   1, 4'd7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 4, 8'd0,   1, 4'd8, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 3, 8'd0,   0, 4'd8, 0, 1));
    // period 0 behaves as 1
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd8,   16'd0, 1, 8'd8,   0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd0, 1, 8'd4,   1, 4'd1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd0, 1, 8'd2,   1, 4'd2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd0, 1, 8'd1,   1, 4'd3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd0, 1, 8'd0,   1, 4'd4, 0, 1));
    // up out of EXPIRED -> IDLE with out=1, then static
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,   16'd0, 1, 8'd1,   0, 4'd4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd0, 3, 8'd1,   0, 4'd4, 0, 0));
    // hold delays first halving from E+3 to E+8
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd100, 16'd3, 1, 8'd100, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd3, 1, 8'd100, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'd0,   16'd3, 5, 8'd100, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd3, 1, 8'd100, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd3, 1, 8'd50,  1, 4'd1, 1, 0));
    // reset mid-decay at out=50
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'd0,   16'd3, 1, 8'd0,   0, 4'd0, 0, 0));
    // load 0 -> IDLE
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,   16'd5, 1, 8'd0,   0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd5, 2, 8'd0,   0, 4'd0, 0, 0));
    // up saturates at 255 and freezes the prescaler
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd255, 16'd2, 1, 8'd255, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,   16'd2, 2, 8'd255, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd2, 1, 8'd255, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd2, 1, 8'd127, 1, 4'd1, 1, 0));
    // down to zero in DECAY -> IDLE, not expired; down saturates at 0
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd1,   16'd4, 1, 8'd1,   0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,   16'd4, 1, 8'd0,   0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,   16'd4, 1, 8'd0,   0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd4, 5, 8'd0,   0, 4'd0, 0, 0));
    // load beats a pending halving; period changes mid-decay are ignored
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd8,   16'd1, 1, 8'd8,   0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd1, 1, 8'd4,   1, 4'd1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd6,   16'd2, 1, 8'd6,   0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd9, 1, 8'd6,   0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,   16'd9, 1, 8'd3,   1, 4'd1, 1, 0));

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].rst, vecs[v].ld, vecs[v].up, vecs[v].dn, vecs[v].hold,
            vecs[v].din, vecs[v].per);
      for (int r = 0; r < vecs[v].reps; r++) begin
        @(posedge clk);
        #1;
        if (r < vecs[v].reps - 1) chk("tick_mid", v, 32'(tick0), 32'(1'b0));
      end
      chk("out", v, 32'(out0), 32'(vecs[v].e_out));
      chk("half_tick", v, 32'(tick0), 32'(vecs[v].e_tick));
      chk("halvings", v, 32'(halv0), 32'(vecs[v].e_halv));
      chk("busy", v, 32'(busy0), 32'(vecs[v].e_busy));
      chk("expired", v, 32'(exp0), 32'(vecs[v].e_exp));
      $display("vec %0d: out=%0d tick=%0d halv=%0d busy=%0d exp=%0d",
               v, out0, tick0, halv0, busy0, exp0);
    end

    // Round-half-up decay of 200 with period 1 on the ROUND=1 instance.
    begin
      logic [7:0] seq [9];
      seq = '{8'd100, 8'd50, 8'd25, 8'd13, 8'd7, 8'd4, 8'd2, 8'd1, 8'd0};
      drive(1'b1, 0, 0, 0, 0, 8'd0, 16'd0);
      @(posedge clk); #1;
      drive(1'b0, 1, 0, 0, 0, 8'd200, 16'd1);
      @(posedge clk); #1;
      chk("r1_load_out", 0, 32'(out1), 32'd200);
      chk("r1_load_busy", 0, 32'(busy1), 32'd1);
      drive(1'b0, 0, 0, 0, 0, 8'd0, 16'd1);
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        chk("r1_out", i, 32'(out1), 32'(seq[i]));
        chk("r1_tick", i, 32'(tick1), 32'd1);
        chk("r1_halv", i, 32'(halv1), 32'(i + 1));
        $display("r1 step %0d: out=%0d tick=%0d halv=%0d", i, out1, tick1, halv1);
      end
      chk("r1_expired", 0, 32'(exp1), 32'd1);
      chk("r1_busy", 0, 32'(busy1), 32'd0);
      @(posedge clk); #1;
      chk("r1_tick_after", 0, 32'(tick1), 32'd0);
      chk("r1_halv_after", 0, 32'(halv1), 32'd9);
    end

    // Reset on the very edge of a pending halving: no tick, all cleared.
    drive(1'b0, 1, 0, 0, 0, 8'd40, 16'd1);
    @(posedge clk); #1;
    drive(1'b1, 0, 0, 0, 0, 8'd0, 16'd1);
    @(posedge clk); #1;
    chk("rst_pend_out", 0, 32'(out0), 32'd0);
    chk("rst_pend_tick", 0, 32'(tick0), 32'd0);
    chk("rst_pend_busy", 0, 32'(busy0), 32'd0);
    $display("rst on pending halving: out=%0d tick=%0d busy=%0d", out0, tick0, busy0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
